led_frame_serializer: RTL
=========================

# led_frame_serializer

Upstream driver for the 32-bit LED shift-register chain (four cascaded 8-bit 595-style stages, outputs D = MSB … A = LSB). Accepts 32-bit frames over a valid/ready handshake and buffers one frame. Serialises each frame MSB-first onto DS with generated SHCP/STCP strobes. Drives active-low OE with an 8-bit PWM for global brightness, blanking until the first frame has been latched.

## Interface
Parameters:
- CLK_DIV, 2: clk cycles per SHCP half-period (≥1); also STCP high time.
- FRAME_W, 32: chain length in bits (from package).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  frame; bit 31 → out_D[7], bit 0 → out_A[0].
- in_valid  in  1  frame offered.
- in_ready  out  1  skid buffer empty; transfer on in_valid & in_ready.
- bright  in  8  PWM duty (0 = dark, 255 = 255/256 on).
- DS  out  1  serial data to chain.
- SHCP  out  1  shift clock to chain.
- STCP  out  1  storage (latch) clock to chain.
- OE  out  1  output enable, active low.
- busy  out  1  shifting or latching in progress.
- frame_done  out  1  one-cycle pulse when STCP falls.

## Operation
- Reset values: DS=0, SHCP=0, STCP=0, OE=1, busy=0, frame_done=0, in_ready=1; buffer empty; shifter, bit counter, divider, PWM counter = 0; shown flag cleared.
- Storage: one-entry skid buffer plus 32-bit shifter. in_ready = buffer empty.
- States: IDLE, SHIFT, LATCH.
- IDLE: SHCP=STCP=0. If buffer full, move buffer → shifter, clear buffer, go SHIFT. If in_valid & in_ready while IDLE with empty buffer, data goes directly to shifter, go SHIFT next cycle.
- SHIFT: per bit, low phase of CLK_DIV cycles (DS = shifter[31], SHCP=0), then high phase of CLK_DIV cycles (SHCP=1). Shift left at end of high phase. After bit 31's high phase → LATCH.
- LATCH: STCP=1 for CLK_DIV cycles, DS=0. Then STCP=0, frame_done=1 for one cycle, set shown flag, go IDLE.
- DS changes only when SHCP is low, never on an SHCP rising edge.
- Buffer accepts a new frame during SHIFT/LATCH; a second frame stalls (in_ready=0) until the buffer drains.
- Simultaneous drain and fill in the same cycle: old buffer → shifter, new data → buffer, in_ready remains 1.
- PWM: free-running 8-bit counter on clk. bright is sampled when the counter wraps to 0. OE = ~(shown & cnt < bright_q).
- rst mid-frame: abort immediately to reset values. Partial data left in the chain is not latched. OE blanks until a full new frame latches.

## Timing
- Accept at edge t, engine idle and empty: SHIFT from t+1. Bit k SHCP rises at t+1+CLK_DIV+2·CLK_DIV·k.
- STCP high cycles t+1+64·CLK_DIV … t+65·CLK_DIV. frame_done at t+1+65·CLK_DIV.
- Back-to-back buffered frames: period 65·CLK_DIV+1 cycles (131 at default).
- busy = 1 throughout SHIFT and LATCH, 0 in IDLE.
- bright change visible within ≤256 cycles, at PWM period boundary only.

## Structure
- Package led_pkg: FRAME_W=32, state enum (IDLE/SHIFT/LATCH), default CLK_DIV.
- Sub-module led_pwm_dimmer: counter, bright sampling, shown gating → OE.
- Top: handshake buffer, FSM, divider counter, bit counter (5-bit), shifter.

## Test plan
- Reset: hold rst 3 cycles mid-SHIFT → DS=SHCP=STCP=0, OE=1, in_ready=1, busy=0; chain model unchanged.
- Single frame 32'hFF00_A5C3, bright=255, CLK_DIV=2 → 32 SHCP rises. Chain model out_D..A = FF,00,A5,C3 after STCP. frame_done at t+131.
- Back-to-back: frames 32'h1, 32'h8000_0000 offered continuously → second accepted during first shift. Third stalls until first frame_done. Latch-to-latch spacing 131 cycles.
- Simultaneous drain/fill: offer frame on the cycle IDLE loads from buffer → accepted, in_ready stays 1, three frames latched in order.
- PWM: bright=0 → OE constant 1. bright=64 → 64 low cycles per 256. bright 64→200 mid-period → change only at counter wrap.
- Blanking: before first latch with bright=255 → OE=1. After first frame_done → OE pulses low.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// led_pkg: shared constants and FSM state type for the LED chain driver.
// Revision: 1.0
// ============================================================================
package led_pkg;

    localparam int FRAME_W         = 32;
    localparam int BIT_CNT_W       = $clog2(FRAME_W);
    localparam int DEFAULT_CLK_DIV = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/led_pwm_dimmer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// led_pwm_dimmer: 8-bit brightness PWM on active-low OE, dark until first latch.
// Revision: 1.0
// ============================================================================
module led_pwm_dimmer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bright,
    input  logic       latch_done,
    output logic       oe_n
);

    logic [7:0] r_cnt;
    logic [7:0] r_bright;
    logic       r_shown;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 8'd0;
            r_bright <= 8'd0;
            r_shown  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
            // Duty only changes on a period boundary so no partial period is seen
            if (r_cnt == 8'hFF) begin
                r_bright <= bright;
            end
            if (latch_done) begin
                r_shown <= 1'b1;
            end
        end
    end

    assign oe_n = ~(r_shown & (r_cnt < r_bright));

endmodule
`default_nettype wire

// File: rtl/led_frame_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// led_frame_serializer: buffers 32-bit frames and shifts them MSB-first into
// a 595-style chain with SHCP/STCP strobes and PWM-dimmed OE.
// Revision: 1.0
// ============================================================================
module led_frame_serializer
    import led_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         bright,
    output logic               DS,
    output logic               SHCP,
    output logic               STCP,
    output logic               OE,
    output logic               busy,
    output logic               frame_done
);

    localparam int                   DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]     c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] c_bit_last = BIT_CNT_W'(FRAME_W - 1);

    state_t               r_state;
    logic [FRAME_W-1:0]   r_buf;
    logic                 r_buf_full;
    logic [FRAME_W-1:0]   r_shift;
    logic [DIV_W-1:0]     r_div;
    logic                 r_hi;
    logic [BIT_CNT_W-1:0] r_bit;
    logic                 w_accept;

    // In IDLE a full buffer drains on this edge, so a new frame can refill it
    assign in_ready = ~r_buf_full | (r_state == IDLE);
    assign w_accept = in_valid & in_ready;
    assign DS       = (r_state == SHIFT) & r_shift[FRAME_W-1];
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_shift    <= '0;
            r_div      <= '0;
            r_hi       <= 1'b0;
            r_bit      <= '0;
            SHCP       <= 1'b0;
            STCP       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_accept && (r_state != IDLE)) begin
                r_buf      <= in_data;
                r_buf_full <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    SHCP  <= 1'b0;
                    STCP  <= 1'b0;
                    r_div <= '0;
                    r_hi  <= 1'b0;
                    r_bit <= '0;
                    if (r_buf_full) begin
                        r_shift <= r_buf;
                        r_state <= SHIFT;
                        if (in_valid) begin
                            r_buf <= in_data;
                        end else begin
                            r_buf_full <= 1'b0;
                        end
                    end else if (in_valid) begin
                        r_shift <= in_data;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_div == c_div_last) begin
                        r_div <= '0;
                        if (!r_hi) begin
                            r_hi <= 1'b1;
                            SHCP <= 1'b1;
                        end else begin
                            // Next bit appears on DS together with the SHCP fall
                            r_hi    <= 1'b0;
                            SHCP    <= 1'b0;
                            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                            if (r_bit == c_bit_last) begin
                                r_state <= LATCH;
                                STCP    <= 1'b1;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                LATCH: begin
                    if (r_div == c_div_last) begin
                        r_div      <= '0;
                        STCP       <= 1'b0;
                        frame_done <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    led_pwm_dimmer u_pwm (
        .clk        (clk),
        .rst        (rst),
        .bright     (bright),
        .latch_done (frame_done),
        .oe_n       (OE)
    );

endmodule
`default_nettype wire
